// File: rtl/alu_pkg.sv
// Purpose: shared ALU opcodes, default widths and sequencer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ALU_ADD/ALU_SUB opcodes, DATA_WIDTH_DFLT/CTRL_WIDTH_DFLT, state_t.
package alu_pkg;

   localparam int DATA_WIDTH_DFLT = 32;
   localparam int CTRL_WIDTH_DFLT = 4;

   // Opcodes already understood by the shared ALU.
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_share_ctrl_arb.sv
// Purpose: 2-way round-robin arbiter owning the last-grant pointer.
// Latency: grant is combinational in req; pointer updates on the edge where advance=1.
// Backpressure: none; the caller decides when a grant is consumed via advance.
// Ports: clk, rst (sync, active-high), req[1:0] in, advance in, grant[1:0] one-hot out.
module rr_arb2
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   // last_q = index of the most recently granted requester. Resets to 1 so
   // requester 0 wins the first tie.
   logic last_q;
   logic last_d;

   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (advance && (grant != 2'b00)) begin
         last_d = grant[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Purpose: shares one combinational ALU between two requesters, round-robin, one op in flight.
// Latency: accept at edge T, response valid from cycle T+2; at least 3 cycles per op.
// Backpressure: requests held off (ready=0) while busy; response held until rspN_ready.
// Ports: reqN_valid/ready/a/b/ctrl request channels; rspN_valid/ready + shared rsp_result;
//        alu_a/alu_b/alu_ctrl to the ALU, alu_result from it; busy = not IDLE.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
   parameter int CTRL_WIDTH = CTRL_WIDTH_DFLT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   input  logic [CTRL_WIDTH-1:0] req0_ctrl,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   input  logic [CTRL_WIDTH-1:0] req1_ctrl,
   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [CTRL_WIDTH-1:0] alu_ctrl,
   input  logic [DATA_WIDTH-1:0] alu_result,
   output logic                  busy
);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
   logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
   logic [CTRL_WIDTH-1:0] alu_ctrl_q, alu_ctrl_d;
   logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic                  owner_q, owner_d;

   logic [1:0] grant;
   logic       accept;
   logic       rsp_taken;

   // Acceptance only in IDLE; rst masks ready so nothing is handshaken on a reset edge.
   assign accept = (state_q == IDLE) && (grant != 2'b00) && !rst;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({req1_valid, req0_valid}),
      .advance (accept),
      .grant   (grant)
   );

   assign rsp_taken = owner_q ? rsp1_ready : rsp0_ready;

   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_ctrl_d   = alu_ctrl_q;
      rsp_result_d = rsp_result_q;
      owner_d      = owner_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d    = grant[1];
               alu_a_d    = grant[1] ? req1_a    : req0_a;
               alu_b_d    = grant[1] ? req1_b    : req0_b;
               alu_ctrl_d = grant[1] ? req1_ctrl : req0_ctrl;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            // ALU has had a full cycle on the registered operands.
            rsp_result_d = alu_result;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_taken) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= '0;
         rsp_result_q <= '0;
         owner_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_ctrl_q   <= alu_ctrl_d;
         rsp_result_q <= rsp_result_d;
         owner_q      <= owner_d;
      end
   end

   assign req0_ready = accept && grant[0];
   assign req1_ready = accept && grant[1];
   assign rsp0_valid = (state_q == RESP) && !owner_q;
   assign rsp1_valid = (state_q == RESP) &&  owner_q;
   assign rsp_result = rsp_result_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_ctrl   = alu_ctrl_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Purpose: self-checking bench for alu_share_ctrl with a behavioural ALU and result scoreboard.
// Latency: n/a.
// Backpressure: exercised by holding rspN_ready low.
module tb_alu_share_ctrl;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] rsp_result, alu_a, alu_b, alu_result;
   logic [3:0]  alu_ctrl;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   // {owner, result}: expected pushed on accept, observed pushed on consume.
   logic [32:0] exp_q[$];
   logic [32:0] got_q[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] c);
      if (c == ALU_ADD) return a + b;
      if (c == ALU_SUB) return a - b;
      return a ^ b;
   endfunction

   assign alu_result = alu_model(alu_a, alu_b, alu_ctrl);

   alu_share_ctrl #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ctrl(req1_ctrl),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
      .busy(busy)
   );

   always @(negedge clk) begin
      if (!rst) begin
         if (req0_valid && req0_ready) exp_q.push_back({1'b0, alu_model(req0_a, req0_b, req0_ctrl)});
         if (req1_valid && req1_ready) exp_q.push_back({1'b1, alu_model(req1_a, req1_b, req1_ctrl)});
         if (rsp0_valid && rsp0_ready) got_q.push_back({1'b0, rsp_result});
         if (rsp1_valid && rsp1_ready) got_q.push_back({1'b1, rsp_result});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
      req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c;
   endtask

   task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
      req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c;
   endtask

   task automatic run_op(input bit port, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
      int sz;
      bit seen;
      sz = got_q.size();
      if (port) begin drive1(1'b1, a, b, c); rsp1_ready = 1'b1; end
      else      begin drive0(1'b1, a, b, c); rsp0_ready = 1'b1; end
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = port ? req1_ready : req0_ready;
      end
      tick();
      if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
      n_cmp++;
      if (!seen) begin n_fail++; $display("FAIL run_op_accept: ready seen=%0d required=1", seen); end
      for (int k = 0; k < 20 && got_q.size() == sz; k++) tick();
      n_cmp++;
      if (got_q.size() == sz) begin n_fail++; $display("FAIL run_op_rsp: no response within bound"); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_cmp++; if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b0) begin
         n_fail++; $display("FAIL reset_handshake: got %b required 0000", {rsp0_valid, rsp1_valid, req0_ready, req1_ready}); end
      n_cmp++; if ({alu_a, alu_b, alu_ctrl, rsp_result} !== '0) begin
         n_fail++; $display("FAIL reset_regs: got a=%h b=%h c=%h r=%h required 0", alu_a, alu_b, alu_ctrl, rsp_result); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single();
      exp_q.delete(); got_q.delete();
      drive0(1'b1, 32'd3, 32'd4, ALU_ADD);
      rsp0_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (req0_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL single_c0: ready=%b busy=%b required 1/0", req0_ready, busy); end
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1 || rsp0_valid !== 1'b0 || alu_a !== 32'd3 || alu_b !== 32'd4) begin
         n_fail++; $display("FAIL single_c1: busy=%b v=%b a=%h b=%h required 1/0/3/4", busy, rsp0_valid, alu_a, alu_b); end
      @(negedge clk);
      n_cmp++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 32'd7) begin
         n_fail++; $display("FAIL single_c2: v0=%b v1=%b r=%h required 1/0/7", rsp0_valid, rsp1_valid, rsp_result); end
      tick();
      n_cmp++; if (got_q.size() != 1 || exp_q.size() != 1) begin
         n_fail++; $display("FAIL single_sb_count: got %0d exp %0d required 1/1", got_q.size(), exp_q.size()); end
      else begin
         n_cmp++; if (got_q[0] !== 33'h0_0000_0007 || got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL single_sb: got %h exp %h required 000000007", got_q[0], exp_q[0]); end
      end
   endtask

   task automatic test_round_robin();
      logic [32:0] want[4];
      want[0] = {1'b0, 32'd3}; want[1] = {1'b1, 32'd15};
      want[2] = {1'b0, 32'd3}; want[3] = {1'b1, 32'd15};
      rst = 1'b1; tick(); rst = 1'b0;
      exp_q.delete(); got_q.delete();
      drive0(1'b1, 32'd7, 32'd4, ALU_SUB);
      drive1(1'b1, 32'd10, 32'd5, ALU_ADD);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int k = 0; k < 40 && got_q.size() < 4; k++) tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      n_cmp++; if (got_q.size() < 4) begin
         n_fail++; $display("FAIL rr_count: got %0d responses required 4", got_q.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++; if (got_q[i] !== want[i] || exp_q[i] !== want[i]) begin
               n_fail++; $display("FAIL rr_op%0d: got %h exp %h required %h", i, got_q[i], exp_q[i], want[i]); end
         end
      end
      tick();
   endtask

   task automatic test_back_pressure();
      bit seen;
      exp_q.delete(); got_q.delete();
      drive1(1'b1, 32'd3, 32'd4, ALU_ADD);
      rsp1_ready = 1'b0; rsp0_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin @(negedge clk); seen = req1_ready; end
      tick();
      req1_valid = 1'b0;
      drive0(1'b1, 32'd1, 32'd1, ALU_ADD);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin @(negedge clk); seen = rsp1_valid; end
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL bp_rsp: rsp1_valid never seen"); end
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (rsp1_valid !== 1'b1 || rsp_result !== 32'd7 || req0_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold%0d: v1=%b r=%h rdy0=%b required 1/7/0", k, rsp1_valid, rsp_result, req0_ready); end
         @(negedge clk);
      end
      tick();
      rsp1_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin @(negedge clk); seen = req0_ready; end
      tick();
      req0_valid = 1'b0;
      for (int k = 0; k < 20 && got_q.size() < 2; k++) tick();
      n_cmp++; if (got_q.size() != 2 || exp_q.size() != 2) begin
         n_fail++; $display("FAIL bp_count: got %0d exp %0d required 2/2", got_q.size(), exp_q.size()); end
      else begin
         n_cmp++; if (got_q[0] !== {1'b1, 32'd7} || got_q[1] !== {1'b0, 32'd2} ||
                      exp_q[0] !== got_q[0] || exp_q[1] !== got_q[1]) begin
            n_fail++; $display("FAIL bp_order: got %h,%h required 100000007,000000002", got_q[0], got_q[1]); end
      end
   endtask

   task automatic test_wrap();
      exp_q.delete(); got_q.delete();
      run_op(1'b0, 32'hFFFF_FFFF, 32'd1, ALU_ADD);
      run_op(1'b0, 32'd0, 32'd1, ALU_SUB);
      n_cmp++; if (got_q.size() != 2 || exp_q.size() != 2) begin
         n_fail++; $display("FAIL wrap_count: got %0d exp %0d required 2/2", got_q.size(), exp_q.size()); end
      else begin
         n_cmp++; if (got_q[0] !== {1'b0, 32'h0} || exp_q[0] !== got_q[0]) begin
            n_fail++; $display("FAIL wrap_add: got %h required 000000000", got_q[0]); end
         n_cmp++; if (got_q[1] !== {1'b0, 32'hFFFF_FFFF} || exp_q[1] !== got_q[1]) begin
            n_fail++; $display("FAIL wrap_sub: got %h required 0ffffffff", got_q[1]); end
      end
   endtask

   task automatic test_reset_midop();
      bit seen;
      exp_q.delete(); got_q.delete();
      drive0(1'b1, 32'd5, 32'd6, ALU_ADD);
      rsp0_ready = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin @(negedge clk); seen = req0_ready; end
      tick();
      req0_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin @(negedge clk); seen = rsp0_valid; end
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL rm_resp: rsp0_valid never seen"); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000 || {alu_a, alu_b, alu_ctrl} !== '0) begin
         n_fail++; $display("FAIL rm_after: v0=%b v1=%b busy=%b a=%h b=%h c=%h required all 0",
                            rsp0_valid, rsp1_valid, busy, alu_a, alu_b, alu_ctrl); end
      n_cmp++; if (got_q.size() != 0) begin
         n_fail++; $display("FAIL rm_dropped: got %0d responses required 0", got_q.size()); end
      tick();
      exp_q.delete();
      drive0(1'b1, 32'd2, 32'd2, ALU_ADD);
      drive1(1'b1, 32'd9, 32'd1, ALU_SUB);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         n_fail++; $display("FAIL rm_grant: rdy0=%b rdy1=%b required 1/0", req0_ready, req1_ready); end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int k = 0; k < 20 && got_q.size() < 1; k++) tick();
      n_cmp++; if (got_q.size() != 1 || got_q[0] !== {1'b0, 32'd4} || exp_q[0] !== got_q[0]) begin
         n_fail++; $display("FAIL rm_next_op: got %0d entries first %h required 1 x 000000004",
                            got_q.size(), (got_q.size() > 0) ? got_q[0] : 33'h0); end
   endtask

   task automatic test_withdrawn();
      bit seen;
      exp_q.delete(); got_q.delete();
      drive0(1'b1, 32'd8, 32'd1, ALU_SUB);
      rsp0_ready = 1'b0; rsp1_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin @(negedge clk); seen = req0_ready; end
      tick();
      req0_valid = 1'b0;
      drive1(1'b1, 32'd1, 32'd2, ALU_ADD);
      @(negedge clk);
      n_cmp++; if (req1_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL wd_held: rdy1=%b busy=%b required 0/1", req1_ready, busy); end
      tick();
      req1_valid = 1'b0;
      tick();
      rsp0_ready = 1'b1;
      for (int k = 0; k < 20 && got_q.size() < 1; k++) tick();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++; if (rsp1_valid !== 1'b0) begin
            n_fail++; $display("FAIL wd_rsp1_%0d: rsp1_valid=%b required 0", k, rsp1_valid); end
      end
      n_cmp++; if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== {1'b0, 32'd7}) begin
         n_fail++; $display("FAIL wd_sb: got %0d exp %0d entries required 1/1 with 000000007",
                            got_q.size(), exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_back_pressure();
      test_wrap();
      test_reset_midop();
      test_withdrawn();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
